rv_run_ctrl: RTL and testbench

Run/step sequencer for the single-cycle RV32I core. Owns the core's clock enable and core reset. Lets a debug front end (switches, UART monitor) hold, single-step, free-run and soft-reset the core, and stops execution on an `ebreak` instruction or a PC breakpoint. Sits between the board-level control inputs and the core's `clock`/`reset` pins and counts retired instructions.

---
 rtl/rv_run_ctrl_pkg.sv | 17 +
 rtl/rv_stop_detect.sv | 34 +++
 rtl/rv_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rv_run_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_run_ctrl_pkg.sv
// Shared encodings for the RV32I run/step sequencer: FSM states, halt causes
// and the default ebreak instruction word.
package rv_run_ctrl_pkg;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    localparam logic [1:0] CAUSE_RESET  = 2'b00;
    localparam logic [1:0] CAUSE_USER   = 2'b01;
    localparam logic [1:0] CAUSE_EBREAK = 2'b10;
    localparam logic [1:0] CAUSE_BKPT   = 2'b11;

    localparam logic [31:0] EBREAK_DEFAULT = 32'h0010_0073;

endpackage

// File: rtl/rv_stop_detect.sv
// Combinational stop detector: ebreak match, plus PC breakpoint match when
// RV_RUN_CTRL_BREAKPOINT_EN is defined.
module rv_stop_detect
    import rv_run_ctrl_pkg::*;
#(
    parameter logic [31:0] EBREAK_WORD = EBREAK_DEFAULT
) (
    input  logic [31:0] instr,
`ifdef RV_RUN_CTRL_BREAKPOINT_EN
    input  logic [31:0] pc,
    input  logic [31:0] bp_reg,
    input  logic        bp_armed,
`endif
    output logic        stop,
    output logic [1:0]  cause
);

    logic ebreak_hit;

    assign ebreak_hit = (instr == EBREAK_WORD);

`ifdef RV_RUN_CTRL_BREAKPOINT_EN
    logic bp_hit;

    assign bp_hit = bp_armed && (pc == bp_reg);
    assign stop   = ebreak_hit || bp_hit;
    // ebreak wins when both match on the same instruction
    assign cause  = ebreak_hit ? CAUSE_EBREAK : CAUSE_BKPT;
`else
    assign stop   = ebreak_hit;
    assign cause  = CAUSE_EBREAK;
`endif

endmodule

// File: rtl/rv_run_ctrl.sv
// Run/step sequencer owning the core clock enable and core reset.
// Optional PC breakpoint is built when RV_RUN_CTRL_BREAKPOINT_EN is defined.
//
// state | meaning
// RST   | core held in reset for RST_CYCLES cycles
// HALT  | core stopped, waiting for step/run
// STEP  | one instruction committed, then back to HALT
// RUN   | free-running until halt request, ebreak or breakpoint
module rv_run_ctrl
    import rv_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 4,
    parameter bit          AUTORUN     = 1'b0,
    parameter logic [31:0] EBREAK_WORD = EBREAK_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        srst_req,
    input  logic        bp_wr,
    input  logic        bp_clr,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        cpu_ce,
    output logic        cpu_rst,
    output logic        running,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] nxt;
    logic [7:0] rst_cnt;
    logic       resume;
    logic       ce;
    logic       rst_entry;
    logic       set_resume;
    logic       cause_load;
    logic [1:0] cause_val;
    logic       stop;
    logic [1:0] stop_cause;

`ifdef RV_RUN_CTRL_BREAKPOINT_EN
    logic [31:0] bp_reg;
    logic        bp_armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            bp_reg   <= '0;
            bp_armed <= 1'b0;
        end else if (bp_clr) begin
            bp_armed <= 1'b0;
        end else if (bp_wr) begin
            bp_reg   <= bp_addr;
            bp_armed <= 1'b1;
        end
    end

    rv_stop_detect #(.EBREAK_WORD(EBREAK_WORD)) u_stop (
        .instr    (instr),
        .pc       (pc),
        .bp_reg   (bp_reg),
        .bp_armed (bp_armed),
        .stop     (stop),
        .cause    (stop_cause)
    );
`else
    logic unused_bp;
    assign unused_bp = &{1'b0, bp_wr, bp_clr, bp_addr, pc};

    rv_stop_detect #(.EBREAK_WORD(EBREAK_WORD)) u_stop (
        .instr (instr),
        .stop  (stop),
        .cause (stop_cause)
    );
`endif

    always_comb begin
        nxt        = state;
        ce         = 1'b0;
        rst_entry  = 1'b0;
        set_resume = 1'b0;
        cause_load = 1'b0;
        cause_val  = CAUSE_RESET;
        case (state)
            ST_RST: begin
                if (rst_cnt == RST_LAST) nxt = AUTORUN ? ST_RUN : ST_HALT;
            end
            ST_HALT: begin
                if (step_req) begin
                    nxt = ST_STEP;
                end else if (run_req) begin
                    nxt        = ST_RUN;
                    set_resume = 1'b1;
                end
            end
            ST_STEP: begin
                ce  = 1'b1;
                nxt = ST_HALT;
            end
            default: begin
                if (halt_req) begin
                    nxt        = ST_HALT;
                    cause_load = 1'b1;
                    cause_val  = CAUSE_USER;
                end else if (stop && !resume) begin
                    nxt        = ST_HALT;
                    cause_load = 1'b1;
                    cause_val  = stop_cause;
                end else begin
                    ce = 1'b1;
                end
            end
        endcase
        // soft reset overrides whatever the state wanted this cycle
        if (srst_req) begin
            nxt        = ST_RST;
            ce         = 1'b0;
            rst_entry  = 1'b1;
            set_resume = 1'b0;
            cause_load = 1'b0;
        end
    end

    assign cpu_ce = ce && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RST;
            rst_cnt    <= '0;
            resume     <= 1'b0;
            cpu_rst    <= 1'b1;
            running    <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= CAUSE_RESET;
            retired    <= '0;
        end else begin
            state   <= nxt;
            rst_cnt <= (state == ST_RST && !rst_entry) ? rst_cnt + 8'd1 : 8'd0;
            cpu_rst <= (nxt == ST_RST);
            running <= (nxt == ST_RUN);
            halted  <= (nxt == ST_HALT);

            if (set_resume)           resume <= 1'b1;
            else if (state == ST_RUN) resume <= 1'b0;
            else if (rst_entry)       resume <= 1'b0;

            if (rst_entry)       halt_cause <= CAUSE_RESET;
            else if (cause_load) halt_cause <= cause_val;

            if (rst_entry) retired <= '0;
            else if (ce)   retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Directed self-checking bench for rv_run_ctrl; breakpoint checks follow
// RV_RUN_CTRL_BREAKPOINT_EN.
module tb_rv_run_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset, run_req, step_req, halt_req, srst_req;
    logic        bp_wr, bp_clr;
    logic [31:0] bp_addr, pc, instr;
    logic        cpu_ce, cpu_rst, running, halted;
    logic [1:0]  halt_cause;
    logic [31:0] retired;

    int n_chk = 0;
    int n_fail = 0;
    int ce_cnt = 0;
    int k;

    always #5 clock = ~clock;

    rv_run_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .srst_req   (srst_req),
        .bp_wr      (bp_wr),
        .bp_clr     (bp_clr),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .instr      (instr),
        .cpu_ce     (cpu_ce),
        .cpu_rst    (cpu_rst),
        .running    (running),
        .halted     (halted),
        .halt_cause (halt_cause),
        .retired    (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the commit strobe, cross the edge, advance the PC of
    // the modelled core when it committed, then drop all one-cycle pulses.
    task automatic tick();
        logic c;
        #1;
        c = cpu_ce;
        @(posedge clock);
        #1;
        if (c === 1'b1) begin
            ce_cnt++;
            pc = pc + 32'd4;
        end
        run_req  = 1'b0;
        step_req = 1'b0;
        halt_req = 1'b0;
        srst_req = 1'b0;
        bp_wr    = 1'b0;
        bp_clr   = 1'b0;
    endtask

    task automatic count_rst(output int n);
        n = 0;
        while (cpu_rst === 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_until_halt(output int n);
        n = 0;
        while (halted !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        srst_req = 1'b0; bp_wr = 1'b0; bp_clr = 1'b0; bp_addr = '0;
        pc = '0; instr = NOP;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_cpu_ce", 32'(cpu_ce), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cause", 32'(halt_cause), 0);
        chk("rst_retired", retired, 0);

        reset = 1'b0;
        count_rst(k);
        chk("rst_len", 32'(k), 4);
        chk("rst_exit_halted", 32'(halted), 1);
        chk("rst_exit_cause", 32'(halt_cause), 0);
        chk("rst_exit_retired", retired, 0);

        // three single steps, 3 cycles apart
        ce_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            #1;
            chk("step_pre_ce", 32'(cpu_ce), 0);
            tick();
            chk("step_ce", 32'(cpu_ce), 1);
            chk("step_halted_low", 32'(halted), 0);
            tick();
            chk("step_halted_back", 32'(halted), 1);
            chk("step_ce_off", 32'(cpu_ce), 0);
            tick();
        end
        chk("step_pulses", 32'(ce_cnt), 3);
        chk("step_retired", retired, 3);

        // run, ebreak on the 10th RUN cycle
        ce_cnt = 0;
        run_req = 1'b1;
        tick();
        chk("run_running", 32'(running), 1);
        chk("run_ce", 32'(cpu_ce), 1);
        repeat (9) tick();
        instr = EBRK;
        #1;
        chk("ebreak_ce", 32'(cpu_ce), 0);
        tick();
        chk("ebreak_halted", 32'(halted), 1);
        chk("ebreak_running", 32'(running), 0);
        chk("ebreak_cause", 32'(halt_cause), 2);
        chk("ebreak_commits", 32'(ce_cnt), 9);
        chk("ebreak_retired", retired, 12);

        // resume executes the ebreak once, then checks apply again
        run_req = 1'b1;
        tick();
        chk("resume_ce", 32'(cpu_ce), 1);
        tick();
        chk("resume_cleared_ce", 32'(cpu_ce), 0);
        tick();
        chk("resume_halted", 32'(halted), 1);
        chk("resume_retired", retired, 13);

        // user halt
        instr = NOP;
        run_req = 1'b1;
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        #1;
        chk("halt_ce", 32'(cpu_ce), 0);
        tick();
        chk("halt_halted", 32'(halted), 1);
        chk("halt_cause", 32'(halt_cause), 1);
        chk("halt_retired", retired, 15);
        halt_req = 1'b1;
        tick();
        chk("halt_in_halt", 32'(halted), 1);
        chk("halt_in_halt_cause", 32'(halt_cause), 1);

`ifdef RV_RUN_CTRL_BREAKPOINT_EN
        pc = '0;
        bp_wr = 1'b1;
        bp_addr = 32'h20;
        tick();
        ce_cnt = 0;
        run_req = 1'b1;
        tick();
        run_until_halt(k);
        chk("bp_halted", 32'(halted), 1);
        chk("bp_pc", pc, 32'h20);
        chk("bp_cause", 32'(halt_cause), 3);
        chk("bp_commits", 32'(ce_cnt), 8);
        chk("bp_retired", retired, 23);

        // write and clear together: clear wins, nothing armed at 0x18 or 0x20
        bp_wr = 1'b1;
        bp_clr = 1'b1;
        bp_addr = 32'h18;
        tick();
        pc = 32'h10;
        run_req = 1'b1;
        tick();
        repeat (7) tick();
        chk("bpclr_running", 32'(running), 1);
        chk("bpclr_pc", pc, 32'h2C);
        halt_req = 1'b1;
        tick();
        chk("bpclr_retired", retired, 30);
        bp_wr = 1'b1;
        bp_addr = 32'h40;
        tick();
`else
        pc = '0;
        bp_wr = 1'b1;
        bp_addr = 32'h20;
        tick();
        run_req = 1'b1;
        tick();
        repeat (12) tick();
        chk("nobp_running", 32'(running), 1);
        chk("nobp_pc", pc, 32'h30);
        halt_req = 1'b1;
        tick();
        chk("nobp_retired", retired, 27);
`endif

        // soft reset beats halt in the same cycle
        pc = '0;
        run_req = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        srst_req = 1'b1;
        #1;
        chk("srst_ce", 32'(cpu_ce), 0);
        tick();
        chk("srst_cpu_rst", 32'(cpu_rst), 1);
        chk("srst_running", 32'(running), 0);
        chk("srst_halted", 32'(halted), 0);
        chk("srst_cause", 32'(halt_cause), 0);
        chk("srst_retired", retired, 0);
        count_rst(k);
        chk("srst_len", 32'(k), 4);
        chk("srst_exit_halted", 32'(halted), 1);

`ifdef RV_RUN_CTRL_BREAKPOINT_EN
        pc = 32'h38;
        ce_cnt = 0;
        run_req = 1'b1;
        tick();
        run_until_halt(k);
        chk("srst_bp_pc", pc, 32'h40);
        chk("srst_bp_cause", 32'(halt_cause), 3);
        chk("srst_bp_commits", 32'(ce_cnt), 2);
`endif

        // retired wraps
        force dut.retired = 32'hFFFF_FFFE;
        #1;
        release dut.retired;
        step_req = 1'b1;
        tick();
        tick();
        chk("wrap_ffffffff", retired, 32'hFFFF_FFFF);
        step_req = 1'b1;
        tick();
        tick();
        chk("wrap_zero", retired, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
